zircon_avalon_ir_regfile: RTL and testbench
===========================================

Name: zircon_avalon_ir_regfile

Overview:
Parametrised Avalon-MM slave register file for the IR receiver IP, replacing the single 8-bit data register. It buffers decoded IR codes from the decoder in a FIFO. It exposes data, status, control and interrupt-clear registers, and raises an interrupt to the Nios II when codes are pending or an overflow occurs. It sits between the IR decoder core and the Qsys Avalon interconnect.

Parameters:
DATA_W, 8, width of one decoded IR code (1..32); zero-extended onto avs_readdata.
FIFO_DEPTH, 8, number of buffered codes; power of 2, 2..256.
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level count (derived, not overridable).

Ports:
csi_clk  in  1  system clock
rsi_reset_n  in  1  system reset
avs_address  in  2  word address
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
ins_irq  out  1  level interrupt to CPU
i_ir_data  in  DATA_W  decoded code from IR decoder
i_ir_valid  in  1  one-cycle strobe, i_ir_data valid

Behaviour:
- Reset: rsi_reset_n, asynchronous, active-low; clock csi_clk. All registers are in the csi_clk domain.
- Reset values: avs_readdata=0, ins_irq=0, FIFO empty, level=0, overflow=0, ctrl_en=1, ctrl_irq_en=0.
- Avalon timing: fixed read latency 1. avs_readdata is updated in the cycle after avs_read is sampled and holds until the next read. Zero wait states. Writes take effect at the clock edge on which they are sampled.
- Address map:
  - 0 DATA (R): pops the FIFO head. readdata = {zero, head[DATA_W-1:0]}. A read while empty returns 0, does not pop, and leaves no side effects.
  - 1 STATUS (R): bit0 empty, bit1 full, bit2 overflow (sticky), bits[8+LVL_W-1:8] level, other bits 0.
  - 2 CONTROL (R/W): bit0 en (capture enable), bit1 irq_en. bit2 flush is write-only and self-clearing (reads 0).
  - 3 CLEAR (W): writing 1 to bit0 clears overflow. Reads return 0.
- Writes to DATA/STATUS are ignored. avs_read and avs_write asserted together: both act, with no interaction.
- Push: i_ir_valid=1 and en=1 and not full pushes i_ir_data. i_ir_valid while en=0 is dropped silently.
- Full: push while full drops the new code and sets overflow. Existing contents are untouched.
- Simultaneous push and pop:
  - Not empty: both occur, level unchanged.
  - Empty: the pop is a no-op and readdata=0. The push lands and level becomes 1.
  - Full: the pop frees a slot, so the push is accepted and overflow is not set.
- Flush: the write to CONTROL with bit2=1 empties the FIFO at that edge (pointers and level reset). overflow is unaffected. Flush has priority over a same-cycle push or pop; the pushed code is discarded.
- Overflow clear vs set in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. Level = wptr - rptr using LVL_W-bit pointers (extra MSB distinguishes full from empty).
- ins_irq: registered, = irq_en & (!empty | overflow). It updates one cycle after the causing event and deasserts one cycle after the last pop or overflow clear.
- Reset mid-operation: all state returns to reset values immediately. In-flight reads return 0.

Decomposition:
- Package zircon_ir_pkg:
  - address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_CLEAR=3;
  - bit positions ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_LVL_LSB=8, CTRL_EN=0, CTRL_IRQEN=1, CTRL_FLUSH=2.
- Sub-module zircon_ir_fifo: synchronous FIFO (DATA_W, FIFO_DEPTH).
  - Inputs: push, pop, flush, din.
  - Outputs: dout (head, show-ahead), empty, full, level.
  - The register-file top holds decode, the control/overflow registers, readdata and irq.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001 (empty). Read CONTROL -> 0x1. ins_irq=0.
- irq_en=1. Strobe codes 0x45, 0x46, 0x47 -> STATUS level=3, ins_irq=1 one cycle after the first strobe. Three DATA reads return 0x45, 0x46, 0x47 in order. ins_irq falls after the third pop. A fourth read returns 0.
- FIFO_DEPTH=8: strobe 10 codes -> full=1, overflow=1, level=8. Reads return the first 8 codes. Write CLEAR=1 -> overflow=0.
- Full FIFO: i_ir_valid in the same cycle as a DATA read -> overflow stays 0, level stays 8, the new code is last out.
- en=0, then strobe 0x12 -> level stays 0. Load 3 codes, write CONTROL=0x7 -> level=0, and CONTROL reads back 0x3.
- DATA_W=32, FIFO_DEPTH=2: push 0xDEADBEEF, 0x00FF00FF -> exact 32-bit readback in order. Assert rsi_reset_n=0 mid-sequence -> STATUS=0x1 after reset.

Source files
------------

// File: rtl/zircon_avalon_ir_regfile_pkg.sv
// zircon_ir_pkg: register map constants shared by the IR register file,
// its FIFO and the testbench.
//   ADDR_*  : Avalon word addresses
//   ST_*    : STATUS register bit positions
//   CTRL_*  : CONTROL register bit positions
package zircon_ir_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_FLUSH = 2;
endpackage

// File: rtl/zircon_avalon_ir_regfile_if.sv
// Avalon-MM slave bus for the IR register file.
//   avs_address/avs_read/avs_write/avs_writedata : master -> slave
//   avs_readdata (latency 1), ins_irq (level)     : slave -> master
interface zircon_avalon_ir_regfile_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        ins_irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, ins_irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, ins_irq
  );
endinterface

// File: rtl/zircon_avalon_ir_regfile_fifo.sv
// zircon_ir_fifo: synchronous show-ahead FIFO for decoded IR codes.
//   push/pop : qualified by the caller (no push when full unless popping,
//              no pop when empty)
//   flush    : resets both pointers; beats a same-cycle push/pop
//   dout     : current head, valid while !empty
//   empty/full/level : derived from LVL_W-bit pointers (extra MSB
//              separates full from empty)
module zircon_ir_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            csi_clk,
  input  logic                            rsi_reset_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               dout,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH):0]     level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = LVL_W - 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [LVL_W-1:0]  wptr_q, wptr_d;
  logic [LVL_W-1:0]  rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge csi_clk) begin
    if (push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign level = wptr_q - rptr_q;
  assign empty = (level == '0);
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign dout  = mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/zircon_avalon_ir_regfile.sv
// zircon_avalon_ir_regfile: Avalon-MM register file for the IR receiver.
// Buffers decoded codes in a FIFO and exposes DATA (pop), STATUS,
// CONTROL (en, irq_en, self-clearing flush) and CLEAR (overflow) registers.
//   csi_clk, rsi_reset_n : clock, async active-low reset
//   avs                  : Avalon-MM slave bus (read latency 1) + ins_irq
//   i_ir_data/i_ir_valid : code strobe from the IR decoder
module zircon_avalon_ir_regfile
  import zircon_ir_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset_n,
  zircon_avalon_ir_regfile_if.slave avs,
  input  logic [DATA_W-1:0]       i_ir_data,
  input  logic                    i_ir_valid
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] head;
  logic              empty, full;
  logic [LVL_W-1:0]  level;

  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic rd_data, wr_ctrl, flush, pop, push_req, push, ovf_set, ovf_clr;
  logic unused_wd;

  assign unused_wd = ^avs.avs_writedata[31:3];

  // A pop frees a slot in the same edge, so a full FIFO still takes the push.
  assign rd_data  = avs.avs_read && (avs.avs_address == ADDR_DATA);
  assign wr_ctrl  = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign flush    = wr_ctrl && avs.avs_writedata[CTRL_FLUSH];
  assign pop      = rd_data && !empty;
  assign push_req = i_ir_valid && en_q;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = avs.avs_write && (avs.avs_address == ADDR_CLEAR) &&
                    avs.avs_writedata[0];

  zircon_ir_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rsi_reset_n),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .din         (i_ir_data),
    .dout        (head),
    .empty       (empty),
    .full        (full),
    .level       (level)
  );

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    if (wr_ctrl) begin
      en_d     = avs.avs_writedata[CTRL_EN];
      irq_en_d = avs.avs_writedata[CTRL_IRQEN];
    end

    // Set beats clear when both land on the same edge.
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (avs.avs_read) begin
      rdata_d = '0;
      case (avs.avs_address)
        ADDR_DATA:   if (!empty) rdata_d[DATA_W-1:0] = head;
        ADDR_STATUS: begin
          rdata_d[ST_EMPTY]              = empty;
          rdata_d[ST_FULL]               = full;
          rdata_d[ST_OVF]                = ovf_q;
          rdata_d[ST_LVL_LSB +: LVL_W]   = level;
        end
        ADDR_CTRL: begin
          rdata_d[CTRL_EN]    = en_q;
          rdata_d[CTRL_IRQEN] = irq_en_q;
        end
        default:     rdata_d = '0;
      endcase
    end

    irq_d = irq_en_q && (!empty || ovf_q);
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign avs.ins_irq      = irq_q;
endmodule

// File: tb/tb_zircon_avalon_ir_regfile.sv
module tb_zircon_avalon_ir_regfile;
  import zircon_ir_pkg::*;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic [7:0]  ir0_data;
  logic        ir0_valid;
  logic [31:0] ir1_data;
  logic        ir1_valid;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zircon_avalon_ir_regfile_if bus0();
  zircon_avalon_ir_regfile_if bus1();

  zircon_avalon_ir_regfile #(.DATA_W(8), .FIFO_DEPTH(8)) dut0 (
    .csi_clk(clk), .rsi_reset_n(rst0_n), .avs(bus0),
    .i_ir_data(ir0_data), .i_ir_valid(ir0_valid)
  );

  zircon_avalon_ir_regfile #(.DATA_W(32), .FIFO_DEPTH(2)) dut1 (
    .csi_clk(clk), .rsi_reset_n(rst1_n), .avs(bus1),
    .i_ir_data(ir1_data), .i_ir_valid(ir1_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [1:0] a, output logic [31:0] d);
    bus0.avs_address = a; bus0.avs_read = 1'b1;
    tick();
    bus0.avs_read = 1'b0;
    d = bus0.avs_readdata;
  endtask

  task automatic wr0(input logic [1:0] a, input logic [31:0] d);
    bus0.avs_address = a; bus0.avs_write = 1'b1; bus0.avs_writedata = d;
    tick();
    bus0.avs_write = 1'b0;
  endtask

  task automatic push0(input logic [7:0] c);
    ir0_data = c; ir0_valid = 1'b1;
    tick();
    ir0_valid = 1'b0;
  endtask

  task automatic rd1(input logic [1:0] a, output logic [31:0] d);
    bus1.avs_address = a; bus1.avs_read = 1'b1;
    tick();
    bus1.avs_read = 1'b0;
    d = bus1.avs_readdata;
  endtask

  task automatic push1(input logic [31:0] c);
    ir1_data = c; ir1_valid = 1'b1;
    tick();
    ir1_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus0.avs_address = '0; bus0.avs_read = 0; bus0.avs_write = 0; bus0.avs_writedata = '0;
    bus1.avs_address = '0; bus1.avs_read = 0; bus1.avs_write = 0; bus1.avs_writedata = '0;
    ir0_data = '0; ir0_valid = 0; ir1_data = '0; ir1_valid = 0;
    rst0_n = 0; rst1_n = 0;
    tick(); tick();
    checks++; if (bus0.avs_readdata !== 32'h0) begin failures++;
      $display("FAIL reset_readdata got=%h exp=%h", bus0.avs_readdata, 32'h0); end
    checks++; if (bus0.ins_irq !== 1'b0) begin failures++;
      $display("FAIL reset_irq got=%b exp=0", bus0.ins_irq); end
    rst0_n = 1; rst1_n = 1;
    tick();
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL reset_status got=%h exp=%h", d, 32'h1); end
    rd0(ADDR_CTRL, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h1); end
    checks++; if (bus0.ins_irq !== 1'b0) begin failures++;
      $display("FAIL reset_irq2 got=%b exp=0", bus0.ins_irq); end
  endtask

  task automatic test_irq_order;
    logic [31:0] d;
    logic [7:0] exp_codes [3];
    exp_codes[0] = 8'h45; exp_codes[1] = 8'h46; exp_codes[2] = 8'h47;
    wr0(ADDR_CTRL, 32'h3);
    push0(8'h45);
    checks++; if (bus0.ins_irq !== 1'b0) begin failures++;
      $display("FAIL irq_same_cycle got=%b exp=0", bus0.ins_irq); end
    push0(8'h46);
    checks++; if (bus0.ins_irq !== 1'b1) begin failures++;
      $display("FAIL irq_rise got=%b exp=1", bus0.ins_irq); end
    push0(8'h47);
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h300) begin failures++;
      $display("FAIL status_lvl3 got=%h exp=%h", d, 32'h300); end
    for (int i = 0; i < 3; i++) begin
      rd0(ADDR_DATA, d);
      checks++; if (d !== {24'h0, exp_codes[i]}) begin failures++;
        $display("FAIL data_order[%0d] got=%h exp=%h", i, d, exp_codes[i]); end
    end
    checks++; if (bus0.ins_irq !== 1'b1) begin failures++;
      $display("FAIL irq_hold_after_last_pop got=%b exp=1", bus0.ins_irq); end
    rd0(ADDR_DATA, d);
    checks++; if (d !== 32'h0) begin failures++;
      $display("FAIL empty_read got=%h exp=0", d); end
    checks++; if (bus0.ins_irq !== 1'b0) begin failures++;
      $display("FAIL irq_fall got=%b exp=0", bus0.ins_irq); end
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL status_empty got=%h exp=1", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) push0(8'h10 + 8'(i));
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h806) begin failures++;
      $display("FAIL ovf_status got=%h exp=%h", d, 32'h806); end
    checks++; if (bus0.ins_irq !== 1'b1) begin failures++;
      $display("FAIL ovf_irq got=%b exp=1", bus0.ins_irq); end
    for (int i = 0; i < 8; i++) begin
      rd0(ADDR_DATA, d);
      checks++; if (d !== 32'h10 + 32'(i)) begin failures++;
        $display("FAIL ovf_data[%0d] got=%h exp=%h", i, d, 32'h10 + 32'(i)); end
    end
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h5) begin failures++;
      $display("FAIL ovf_sticky got=%h exp=%h", d, 32'h5); end
    wr0(ADDR_CLEAR, 32'h1);
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL ovf_clear got=%h exp=%h", d, 32'h1); end
    checks++; if (bus0.ins_irq !== 1'b0) begin failures++;
      $display("FAIL irq_after_clear got=%b exp=0", bus0.ins_irq); end
    rd0(ADDR_CLEAR, d);
    checks++; if (d !== 32'h0) begin failures++;
      $display("FAIL clear_reads0 got=%h exp=0", d); end
  endtask

  task automatic test_full_pop_push;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push0(8'h20 + 8'(i));
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h802) begin failures++;
      $display("FAIL full_status got=%h exp=%h", d, 32'h802); end
    bus0.avs_address = ADDR_DATA; bus0.avs_read = 1'b1;
    ir0_data = 8'h28; ir0_valid = 1'b1;
    tick();
    bus0.avs_read = 1'b0; ir0_valid = 1'b0;
    checks++; if (bus0.avs_readdata !== 32'h20) begin failures++;
      $display("FAIL full_simul_read got=%h exp=%h", bus0.avs_readdata, 32'h20); end
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h802) begin failures++;
      $display("FAIL full_simul_status got=%h exp=%h", d, 32'h802); end
    for (int i = 0; i < 8; i++) begin
      rd0(ADDR_DATA, d);
      checks++; if (d !== 32'h21 + 32'(i)) begin failures++;
        $display("FAIL full_simul_data[%0d] got=%h exp=%h", i, d, 32'h21 + 32'(i)); end
    end
  endtask

  task automatic test_empty_pop_push;
    logic [31:0] d;
    bus0.avs_address = ADDR_DATA; bus0.avs_read = 1'b1;
    ir0_data = 8'h55; ir0_valid = 1'b1;
    tick();
    bus0.avs_read = 1'b0; ir0_valid = 1'b0;
    checks++; if (bus0.avs_readdata !== 32'h0) begin failures++;
      $display("FAIL empty_simul_read got=%h exp=0", bus0.avs_readdata); end
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h100) begin failures++;
      $display("FAIL empty_simul_status got=%h exp=%h", d, 32'h100); end
    rd0(ADDR_DATA, d);
    checks++; if (d !== 32'h55) begin failures++;
      $display("FAIL empty_simul_data got=%h exp=%h", d, 32'h55); end
  endtask

  task automatic test_en_flush;
    logic [31:0] d;
    wr0(ADDR_CTRL, 32'h2);
    push0(8'h12);
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL en0_drop got=%h exp=%h", d, 32'h1); end
    wr0(ADDR_CTRL, 32'h3);
    push0(8'h31); push0(8'h32); push0(8'h33);
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h300) begin failures++;
      $display("FAIL preflush_status got=%h exp=%h", d, 32'h300); end
    wr0(ADDR_CTRL, 32'h7);
    rd0(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL flush_status got=%h exp=%h", d, 32'h1); end
    rd0(ADDR_CTRL, d);
    checks++; if (d !== 32'h3) begin failures++;
      $display("FAIL flush_ctrl got=%h exp=%h", d, 32'h3); end
  endtask

  task automatic test_wide_reset;
    logic [31:0] d;
    push1(32'hDEADBEEF);
    push1(32'h00FF00FF);
    rd1(ADDR_STATUS, d);
    checks++; if (d !== 32'h202) begin failures++;
      $display("FAIL wide_status got=%h exp=%h", d, 32'h202); end
    rd1(ADDR_DATA, d);
    checks++; if (d !== 32'hDEADBEEF) begin failures++;
      $display("FAIL wide_data0 got=%h exp=%h", d, 32'hDEADBEEF); end
    rd1(ADDR_DATA, d);
    checks++; if (d !== 32'h00FF00FF) begin failures++;
      $display("FAIL wide_data1 got=%h exp=%h", d, 32'h00FF00FF); end
    push1(32'h11111111);
    bus1.avs_address = ADDR_DATA; bus1.avs_read = 1'b1;
    #2 rst1_n = 1'b0;
    tick();
    bus1.avs_read = 1'b0;
    checks++; if (bus1.avs_readdata !== 32'h0) begin failures++;
      $display("FAIL wide_inflight got=%h exp=0", bus1.avs_readdata); end
    rst1_n = 1'b1;
    tick();
    rd1(ADDR_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++;
      $display("FAIL wide_post_reset got=%h exp=%h", d, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_irq_order();
    test_overflow();
    test_full_pop_push();
    test_empty_pop_push();
    test_en_flush();
    test_wide_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
